// File: rtl/cnt_ctrl_pkg.sv
// Shared definitions for the counter run controller: state encoding and default widths.
package cnt_ctrl_pkg;

    localparam int STATE_W        = 3;
    localparam int REPS_W_DEFAULT = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_RUN  = 3'd2,
        ST_HOLD = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/cnt_run_ctrl.sv
// Run controller owning the 4-bit counter's clear/enable: clear, count R wraps,
// pause/resume, abort, and a one-cycle completion pulse.
module cnt_run_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int REPS_W = REPS_W_DEFAULT
) (
    input  logic              clk,
    input  logic              mr,
    input  logic              start,
    input  logic [REPS_W-1:0] reps,
    input  logic              pause,
    input  logic              abort,
    input  logic [3:0]        q,
    input  logic              co,
    output logic              cnt_mr,
    output logic              cnt_en,
    output logic              busy,
    output logic              done,
    output logic [REPS_W-1:0] runs
);

    localparam logic [REPS_W:0] FULL_TARGET = {1'b1, {REPS_W{1'b0}}};
    localparam logic [REPS_W:0] ONE         = (REPS_W+1)'(1);

    state_t          state_reg, state_next;
    logic [REPS_W:0] target_reg, target_next;
    logic [REPS_W:0] wraps_reg, wraps_next;
    logic [REPS_W:0] wraps_inc;
    logic            cnt_mr_reg, cnt_mr_next;
    logic            cnt_en_reg, cnt_en_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            abort_hit;
    logic            carry_qual;
    logic            unused_q;

    // Q is informational only; it does not steer the run.
    assign unused_q = ^q;

    // A carry counts only if the counter was actually enabled at this edge.
    assign carry_qual = co & cnt_en_reg;
    assign wraps_inc  = wraps_reg + ONE;

    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        wraps_next  = wraps_reg;
        abort_hit   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    target_next = (reps == '0) ? FULL_TARGET : {1'b0, reps};
                    wraps_next  = '0;
                    state_next  = ST_CLR;
                end
            end
            ST_CLR: state_next = ST_RUN;
            ST_RUN: begin
                if (carry_qual) begin
                    wraps_next = wraps_inc;
                end
                if (carry_qual && (wraps_inc == target_reg)) begin
                    state_next = ST_FIN;
                end else if (pause) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!pause) begin
                    state_next = ST_RUN;
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        // Abort overrides everything, including a carry that would have finished the run.
        if (abort && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
            wraps_next = wraps_reg;
            abort_hit  = 1'b1;
        end

        cnt_en_next = (state_next == ST_RUN);
        cnt_mr_next = !((state_next == ST_CLR) || abort_hit);
        done_next   = (state_next == ST_FIN);
        // BUSY rises on the edge leaving CLR and falls on the edge returning to IDLE.
        busy_next   = (state_reg != ST_IDLE) && (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or negedge mr) begin
        if (!mr) begin
            state_reg  <= ST_IDLE;
            target_reg <= '0;
            wraps_reg  <= '0;
            cnt_mr_reg <= 1'b0;
            cnt_en_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            target_reg <= target_next;
            wraps_reg  <= wraps_next;
            cnt_mr_reg <= cnt_mr_next;
            cnt_en_reg <= cnt_en_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign cnt_mr = cnt_mr_reg;
    assign cnt_en = cnt_en_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;
    // A full 2^REPS_W run leaves RUNS at zero because only the low bits are reported.
    assign runs   = wraps_reg[REPS_W-1:0];

endmodule

// File: tb/tb_cnt_run_ctrl.sv
// Scoreboard bench for cnt_run_ctrl driving a behavioural mod-12 counter.
module tb_cnt_run_ctrl;
    import cnt_ctrl_pkg::*;

    localparam int M = 12;

    logic       clk   = 1'b0;
    logic       mr    = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] reps  = 4'd0;
    logic [3:0] q     = 4'd0;
    logic       co;
    logic       cnt_mr, cnt_en, busy, done;
    logic [3:0] runs;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int runs;
        int done;
        int q;
        int mr;
        int busy_len;   // -1: not checked
        int en_len;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;

    cnt_run_ctrl #(.REPS_W(4)) dut (
        .clk    (clk),
        .mr     (mr),
        .start  (start),
        .reps   (reps),
        .pause  (pause),
        .abort  (abort),
        .q      (q),
        .co     (co),
        .cnt_mr (cnt_mr),
        .cnt_en (cnt_en),
        .busy   (busy),
        .done   (done),
        .runs   (runs)
    );

    always #5 clk = ~clk;

    // Team mod-12 counter: async active-low clear, carry at 11 while enabled.
    always @(posedge clk or negedge cnt_mr) begin
        if (!cnt_mr)     q <= 4'd0;
        else if (cnt_en) q <= (q == 4'd11) ? 4'd0 : q + 4'd1;
    end
    assign co = cnt_en && (q == 4'd11);

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // kind: 0 normal, 1 pause, 2 abort, 3 async reset
    function automatic exp_t model(input int reps_v, input int kind, input int p_len, input int a_d);
        exp_t e;
        int r;
        r = (reps_v == 0) ? 16 : reps_v;
        case (kind)
            2: begin
                e.runs = (a_d - 2) / M;   // carries land on offsets 1 + M*j
                e.done = 0; e.q = 0; e.mr = 0;
                e.busy_len = a_d - 1; e.en_len = a_d - 1;
            end
            3: begin
                e.runs = 0; e.done = 0; e.q = 0; e.mr = 0;
                e.busy_len = -1; e.en_len = -1;
            end
            default: begin
                e.runs = r % 16; e.done = 1; e.q = 0; e.mr = 1;
                e.busy_len = M * r + 1 + ((kind == 1) ? p_len : 0);
                e.en_len   = M * r;
            end
        endcase
        return e;
    endfunction

    // Monitor: a run ends when BUSY falls; compare the accumulated run against the scoreboard.
    int   busy_cnt = 0, en_cnt = 0, done_cnt = 0, run_no = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (busy) begin
            busy_cnt++;
            if (cnt_en) en_cnt++;
        end
        if (done) done_cnt++;
        if (prev_busy && !busy) begin
            run_no++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL run_end: run %0d ended with no expected entry", run_no);
            end else begin
                e_mon = exp_q.pop_front();
                $display("run %0d: runs=%0d done=%0d busy_cycles=%0d en_cycles=%0d q=%0d cnt_mr=%0d",
                         run_no, runs, done_cnt, busy_cnt, en_cnt, q, cnt_mr);
                check("end_runs", int'(runs), e_mon.runs);
                check("end_done", done_cnt, e_mon.done);
                check("end_q", int'(q), e_mon.q);
                check("end_cnt_mr", int'(cnt_mr), e_mon.mr);
                if (e_mon.busy_len >= 0) begin
                    check("busy_len", busy_cnt, e_mon.busy_len);
                    check("en_len", en_cnt, e_mon.en_len);
                end
            end
            busy_cnt = 0; en_cnt = 0; done_cnt = 0;
        end
        prev_busy = busy;
    end

    task automatic run_one(input int reps_v, input int kind, input int p_at, input int p_len,
                           input int a_d, input int stray_m);
        int m;
        bit finished;
        exp_q.push_back(model(reps_v, kind, p_len, a_d));
        @(negedge clk);
        reps  = 4'(reps_v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reps  = 4'($urandom);
        check("clr_cnt_mr", int'(cnt_mr), 0);
        check("clr_cnt_en", int'(cnt_en), 0);
        m = 0;
        finished = 0;
        while (!finished && m < 400) begin
            if (m == 1) begin
                check("run_cnt_mr", int'(cnt_mr), 1);
                check("run_cnt_en", int'(cnt_en), 1);
                check("run_busy", int'(busy), 1);
            end
            if (kind == 0 && m == M)     check("runs_before_wrap", int'(runs), 0);
            if (kind == 0 && m == M + 1) check("runs_after_wrap", int'(runs), 1);
            if (kind == 1 && m >= p_at && m < p_at + p_len) begin
                check("hold_cnt_en", int'(cnt_en), 0);
                check("hold_q", int'(q), (p_at - 1) % M);
            end
            pause = (kind == 1) && (m >= p_at - 1) && (m < p_at - 1 + p_len);
            abort = (kind == 2) && (m == a_d - 1);
            start = (m == stray_m);
            if (m == stray_m) reps = 4'($urandom);
            @(negedge clk);
            m++;
            if (m >= 2 && !busy) finished = 1;
        end
        pause = 1'b0; abort = 1'b0; start = 1'b0;
        if (!finished) begin
            checks++; errors++;
            $display("FAIL run_timeout: busy still %0d after %0d cycles", busy, m);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_mid_run();
        int m;
        exp_q.push_back(model(2, 3, 0, 0));
        @(negedge clk);
        reps = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m = 0;
        while (!(q == 4'd7 && cnt_en) && m < 50) begin
            @(negedge clk);
            m++;
        end
        check("reach_q7", int'(q), 7);
        #1 mr = 1'b0;
        #1;
        check("async_cnt_en", int'(cnt_en), 0);
        check("async_cnt_mr", int'(cnt_mr), 0);
        check("async_busy", int'(busy), 0);
        check("async_q", int'(q), 0);
        repeat (2) @(negedge clk);
        check("async_done", int'(done), 0);
        mr = 1'b1;
        @(negedge clk);
        check("post_reset_cnt_mr", int'(cnt_mr), 1);
        check("post_reset_runs", int'(runs), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, kind, p_at, p_len, a_d, stray;
        #1 mr = 1'b0;
        @(negedge clk);
        check("rst_cnt_mr", int'(cnt_mr), 0);
        check("rst_cnt_en", int'(cnt_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_runs", int'(runs), 0);
        @(negedge clk);
        mr = 1'b1;
        #1 check("rst_release_cnt_mr", int'(cnt_mr), 0);
        @(negedge clk);
        check("rst_edge_cnt_mr", int'(cnt_mr), 1);
        check("rst_q", int'(q), 0);

        run_one(2, 0, 0, 0, 0, -1);     // normal REPS=2
        run_one(1, 1, 7, 5, 0, -1);     // pause at Q=6 for 5 cycles
        run_one(3, 2, 0, 0, 18, -1);    // abort at Q=4 in second wrap
        run_one(0, 0, 0, 0, 0, 50);     // REPS=0 with an ignored mid-run START
        reset_mid_run();

        for (int i = 0; i < 14; i++) begin
            r     = $urandom_range(0, 4);
            kind  = $urandom_range(0, 2);
            p_at  = $urandom_range(2, M * ((r == 0) ? 16 : r));
            p_len = $urandom_range(1, 6);
            a_d   = $urandom_range(2, M * ((r == 0) ? 16 : r) + 1);
            stray = (kind != 2 && $urandom_range(0, 1) == 1) ? $urandom_range(2, 10) : -1;
            run_one(r, kind, p_at, p_len, a_d, stray);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
